// File: rtl/adc_sample_seq.sv
// Periodic conversion sequencer for the serial ADC controller.
// Averages 2^AVG_LOG2 samples per batch and tracks min/max, timeout and overrun.
module adc_sample_seq #(
  parameter int AVG_LOG2    = 3,
  parameter int TRIG_PERIOD = 5000,
  parameter int TIMEOUT     = 4000
) (
  input  logic       s_clk,
  input  logic       s_rst,
  input  logic       run,
  output logic       adc_en,
  input  logic [7:0] dout,
  input  logic       con_ok,
  output logic [7:0] avg_data,
  output logic [7:0] min_data,
  output logic [7:0] max_data,
  output logic       avg_vld,
  output logic       timeout_err,
  output logic       ovr_err,
  input  logic       err_clr
);

  localparam int CW = (TRIG_PERIOD > 2) ? $clog2(TRIG_PERIOD) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int AW = 8 + AVG_LOG2;

  localparam logic [CW-1:0]       P_LAST = CW'(TRIG_PERIOD - 1);
  localparam logic [TW-1:0]       T_LAST = TW'(TIMEOUT - 2);
  localparam logic [AVG_LOG2-1:0] N_LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    START,
    WAIT_CONV
  } state_t;

  state_t st, nxt;

  logic [CW-1:0]       cnt;
  logic [TW-1:0]       tcnt;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       sum;
  logic [AVG_LOG2-1:0] n;
  logic [7:0]          mn, mx;
  logic [7:0]          mn_new, mx_new;
  logic                tick, t_hit;
  logic                take, flush, set_to, set_ovr;

  assign tick   = (cnt == P_LAST);
  assign t_hit  = (tcnt == T_LAST);
  assign adc_en = (st == START);
  assign sum    = acc + AW'(dout);
  assign mn_new = (dout < mn) ? dout : mn;
  assign mx_new = (dout > mx) ? dout : mx;

  always_comb begin
    nxt     = st;
    take    = 1'b0;
    flush   = 1'b0;
    set_to  = 1'b0;
    set_ovr = 1'b0;
    unique case (st)
      IDLE: begin
        if (run) nxt = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (tick) nxt = START;
      end
      START: begin
        set_ovr = tick;
        nxt     = WAIT_CONV;
      end
      WAIT_CONV: begin
        set_ovr = tick;
        if (con_ok) begin
          take = 1'b1;
          nxt  = WAIT_TICK;
        end else if (t_hit) begin
          set_to = 1'b1;
          flush  = 1'b1;
          nxt    = WAIT_TICK;
        end
      end
      default: nxt = IDLE;
    endcase
    // Dropping run abandons the batch, even on a completing sample.
    if (st != IDLE && !run) begin
      nxt   = IDLE;
      take  = 1'b0;
      flush = 1'b1;
    end
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      st          <= IDLE;
      cnt         <= '0;
      tcnt        <= '0;
      acc         <= '0;
      n           <= '0;
      mn          <= 8'hFF;
      mx          <= 8'h00;
      avg_data    <= '0;
      min_data    <= '0;
      max_data    <= '0;
      avg_vld     <= 1'b0;
      timeout_err <= 1'b0;
      ovr_err     <= 1'b0;
    end else begin
      st      <= nxt;
      avg_vld <= 1'b0;
      if (st == IDLE || tick) cnt <= '0;
      else cnt <= cnt + CW'(1);
      if (st == START) tcnt <= '0;
      else if (st == WAIT_CONV) tcnt <= tcnt + TW'(1);
      if (flush) begin
        acc <= '0;
        n   <= '0;
        mn  <= 8'hFF;
        mx  <= 8'h00;
      end else if (take) begin
        if (n == N_LAST) begin
          avg_vld  <= 1'b1;
          avg_data <= sum[AW-1:AVG_LOG2];
          min_data <= mn_new;
          max_data <= mx_new;
          acc      <= '0;
          n        <= '0;
          mn       <= 8'hFF;
          mx       <= 8'h00;
        end else begin
          acc <= sum;
          n   <= n + AVG_LOG2'(1);
          mn  <= mn_new;
          mx  <= mx_new;
        end
      end
      timeout_err <= set_to | (timeout_err & ~err_clr);
      ovr_err     <= set_ovr | (ovr_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_adc_sample_seq.sv
// Directed bench for adc_sample_seq with a behavioural adc_ctrl model.
// Scaled periods: main DUT 300/200, overrun DUT 100/400, conversion 126.
module tb_adc_sample_seq;

  localparam int TP  = 300;
  localparam int TO  = 200;
  localparam int TP2 = 100;

  logic       clk = 1'b0;
  logic       s_rst = 1'b1;
  logic       run = 1'b0;
  logic       run2 = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] dout = 8'h00;
  logic       con_ok = 1'b0;

  logic       adc_en, avg_vld, timeout_err, ovr_err;
  logic [7:0] avg_data, min_data, max_data;
  logic       adc_en2, avg_vld2, timeout_err2, ovr_err2;
  logic [7:0] avg_data2, min_data2, max_data2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  adc_sample_seq #(.AVG_LOG2(3), .TRIG_PERIOD(TP), .TIMEOUT(TO)) dut (
    .s_clk(clk), .s_rst(s_rst), .run(run), .adc_en(adc_en),
    .dout(dout), .con_ok(con_ok), .avg_data(avg_data),
    .min_data(min_data), .max_data(max_data), .avg_vld(avg_vld),
    .timeout_err(timeout_err), .ovr_err(ovr_err), .err_clr(err_clr)
  );

  adc_sample_seq #(.AVG_LOG2(3), .TRIG_PERIOD(TP2), .TIMEOUT(400)) dut2 (
    .s_clk(clk), .s_rst(s_rst), .run(run2), .adc_en(adc_en2),
    .dout(dout), .con_ok(con_ok), .avg_data(avg_data2),
    .min_data(min_data2), .max_data(max_data2), .avg_vld(avg_vld2),
    .timeout_err(timeout_err2), .ovr_err(ovr_err2), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // adc_ctrl model: each request pops one queue entry; -1 = never answer
  int         q[$];
  int         conv_delay = 126;
  int         dly = 0;
  int         okc = 0;
  int         v_m;
  bit         pend = 1'b0;
  logic [7:0] nval = 8'h00;

  always @(negedge clk) begin
    con_ok = 1'b0;
    if (pend) begin
      if (dly <= 1) begin
        con_ok = 1'b1;
        dout = nval;
        pend = 1'b0;
        okc++;
      end else dly--;
    end
    if (adc_en || adc_en2) begin
      v_m = (q.size() > 0) ? q.pop_front() : 0;
      if (v_m >= 0) begin
        pend = 1'b1;
        dly = conv_delay;
        nval = v_m[7:0];
      end
    end
  end

  int en_cnt = 0, en_last = 0, en_prev = 0;
  int en2_cnt = 0, en2_last = 0, en2_prev = 0;
  int vld_cnt = 0, to_cyc = 0;
  logic [7:0] v_avg, v_min, v_max;
  logic to_q = 1'b0;

  always @(negedge clk) begin
    if (adc_en) begin
      en_prev = en_last;
      en_last = cyc;
      en_cnt++;
    end
    if (adc_en2) begin
      en2_prev = en2_last;
      en2_last = cyc;
      en2_cnt++;
    end
    if (avg_vld) begin
      vld_cnt++;
      v_avg = avg_data;
      v_min = min_data;
      v_max = max_data;
    end
    if (timeout_err && !to_q) to_cyc = cyc;
    to_q = timeout_err;
  end

  task automatic push_n(input int val, input int k);
    for (int i = 0; i < k; i++) q.push_back(val);
  endtask

  task automatic wait_vld(input string nm);
    int b;
    int i;
    b = vld_cnt;
    i = 0;
    while (vld_cnt == b && i < 4000) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (vld_cnt == b) begin
      failures++;
      $display("FAIL %s: no avg_vld within 4000 cycles", nm);
    end
  endtask

  task automatic wait_en(input string nm);
    int b;
    int i;
    b = en_cnt;
    i = 0;
    while (en_cnt == b && i < 1000) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (en_cnt == b) begin
      failures++;
      $display("FAIL %s: no adc_en within 1000 cycles", nm);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (adc_en !== 1'b0 || avg_vld !== 1'b0) begin
      failures++;
      $display("FAIL rst_pulses: got en=%b vld=%b want 0 0", adc_en, avg_vld);
    end
    checks++;
    if ({avg_data, min_data, max_data} !== 24'h0) begin
      failures++;
      $display("FAIL rst_data: got %h %h %h want 00 00 00",
               avg_data, min_data, max_data);
    end
    checks++;
    if (timeout_err !== 1'b0 || ovr_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_flags: got to=%b ovr=%b want 0 0", timeout_err, ovr_err);
    end
    s_rst = 1'b0;
  endtask

  task automatic test_period;
    int r;
    push_n(8'h80, 8);
    @(negedge clk);
    run = 1'b1;
    r = cyc;
    wait_en("first_en");
    @(negedge clk);
    checks++;
    if (en_last - r !== TP + 1) begin
      failures++;
      $display("FAIL first_en_lat: got %0d want %0d", en_last - r, TP + 1);
    end
    wait_en("second_en");
    @(negedge clk);
    checks++;
    if (en_last - en_prev !== TP) begin
      failures++;
      $display("FAIL en_period: got %0d want %0d", en_last - en_prev, TP);
    end
    wait_vld("batch80");
    checks++;
    if ({v_avg, v_min, v_max} !== 24'h808080) begin
      failures++;
      $display("FAIL batch80: got %h %h %h want 80 80 80", v_avg, v_min, v_max);
    end
    @(negedge clk);
    checks++;
    if (avg_vld !== 1'b0) begin
      failures++;
      $display("FAIL vld_width: avg_vld still %b want 0", avg_vld);
    end
  endtask

  task automatic test_ramp;
    for (int i = 0; i < 8; i++) q.push_back(i);
    wait_vld("ramp");
    checks++;
    if ({v_avg, v_min, v_max} !== 24'h030007) begin
      failures++;
      $display("FAIL ramp: got %h %h %h want 03 00 07", v_avg, v_min, v_max);
    end
    push_n(8'h10, 8);
    wait_vld("flat10");
    checks++;
    if ({v_avg, v_min, v_max} !== 24'h101010) begin
      failures++;
      $display("FAIL flat10: got %h %h %h want 10 10 10", v_avg, v_min, v_max);
    end
  endtask

  task automatic test_extremes;
    push_n(8'hFF, 8);
    wait_vld("allff");
    checks++;
    if ({v_avg, v_min, v_max} !== 24'hFFFFFF) begin
      failures++;
      $display("FAIL allff: got %h %h %h want ff ff ff", v_avg, v_min, v_max);
    end
    for (int i = 0; i < 4; i++) begin
      q.push_back(1);
      q.push_back(0);
    end
    wait_vld("trunc");
    checks++;
    if ({v_avg, v_min, v_max} !== 24'h000001) begin
      failures++;
      $display("FAIL trunc: got %h %h %h want 00 00 01", v_avg, v_min, v_max);
    end
  endtask

  task automatic test_timeout;
    int b;
    int i;
    b = vld_cnt;
    push_n(8'h40, 3);
    q.push_back(-1);
    push_n(8'h20, 8);
    i = 0;
    while (timeout_err !== 1'b1 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL to_set: got %b want 1", timeout_err);
    end
    checks++;
    if (to_cyc - en_last !== TO) begin
      failures++;
      $display("FAIL to_lat: got %0d want %0d", to_cyc - en_last, TO);
    end
    checks++;
    if (vld_cnt !== b) begin
      failures++;
      $display("FAIL to_novld: got %0d pulses want 0", vld_cnt - b);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL to_clr: got %b want 0", timeout_err);
    end
    wait_vld("post_to");
    checks++;
    if ({v_avg, v_min, v_max} !== 24'h202020) begin
      failures++;
      $display("FAIL post_to: got %h %h %h want 20 20 20", v_avg, v_min, v_max);
    end
  endtask

  task automatic test_run_drop;
    int b;
    int i;
    int r;
    b = okc;
    push_n(8'h50, 5);
    i = 0;
    while (okc < b + 5 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    run = 1'b0;
    b = vld_cnt;
    repeat (20) @(negedge clk);
    checks++;
    if (vld_cnt !== b) begin
      failures++;
      $display("FAIL drop_novld: got %0d pulses want 0", vld_cnt - b);
    end
    push_n(8'h30, 8);
    run = 1'b1;
    r = cyc;
    wait_en("rerun_en");
    @(negedge clk);
    checks++;
    if (en_last - r !== TP + 1) begin
      failures++;
      $display("FAIL rerun_lat: got %0d want %0d", en_last - r, TP + 1);
    end
    wait_vld("rerun");
    checks++;
    if ({v_avg, v_min, v_max} !== 24'h303030) begin
      failures++;
      $display("FAIL rerun: got %h %h %h want 30 30 30", v_avg, v_min, v_max);
    end
  endtask

  task automatic test_same_cycle;
    conv_delay = TO - 1;
    push_n(8'h66, 8);
    wait_vld("edge_ok");
    checks++;
    if ({v_avg, v_min, v_max} !== 24'h666666) begin
      failures++;
      $display("FAIL edge_ok: got %h %h %h want 66 66 66", v_avg, v_min, v_max);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL edge_noto: got %b want 0", timeout_err);
    end
    conv_delay = 126;
  endtask

  task automatic test_reset_mid;
    int b;
    int i;
    q.push_back(8'h77);
    wait_en("mid_en");
    repeat (10) @(negedge clk);
    s_rst = 1'b1;
    run = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({avg_data, min_data, max_data} !== 24'h0) begin
      failures++;
      $display("FAIL mid_rst_data: got %h %h %h want 00 00 00",
               avg_data, min_data, max_data);
    end
    checks++;
    if ({adc_en, avg_vld, timeout_err, ovr_err} !== 4'b0) begin
      failures++;
      $display("FAIL mid_rst_bits: got %b want 0000",
               {adc_en, avg_vld, timeout_err, ovr_err});
    end
    s_rst = 1'b0;
    b = okc;
    i = 0;
    while (okc == b && i < 300) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    push_n(8'h08, 8);
    run = 1'b1;
    wait_vld("post_rst");
    checks++;
    if ({v_avg, v_min, v_max} !== 24'h080808) begin
      failures++;
      $display("FAIL post_rst: got %h %h %h want 08 08 08", v_avg, v_min, v_max);
    end
    run = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_overrun;
    int b;
    int i;
    conv_delay = 210;
    b = en2_cnt;
    run2 = 1'b1;
    i = 0;
    while (en2_cnt < b + 2 && i < 1000) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    checks++;
    if (en2_last - en2_prev !== 3 * TP2) begin
      failures++;
      $display("FAIL ovr_spacing: got %0d want %0d", en2_last - en2_prev, 3 * TP2);
    end
    checks++;
    if (ovr_err2 !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set: got %b want 1", ovr_err2);
    end
    checks++;
    if (ovr_err !== 1'b0 || timeout_err2 !== 1'b0) begin
      failures++;
      $display("FAIL ovr_other: got ovr_main=%b to2=%b want 0 0",
               ovr_err, timeout_err2);
    end
    run2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_period();
    test_ramp();
    test_extremes();
    test_timeout();
    test_run_drop();
    test_same_cycle();
    test_reset_mid();
    test_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
